// File: rtl/gpr_file_if.sv
`default_nettype none
// ============================================================================
// Module      : gpr_file_if
// Description : IDU/WBU-facing bus of the general-purpose register file.
// Revision    : 1.0
// ============================================================================
interface gpr_file_if #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 5
);
    // Write-back handshake and write port
    logic              i_sys_valid;
    logic              o_sys_ready;
    logic              i_wbu_gpr_wr_en;
    logic [ID_W-1:0]   i_wbu_gpr_wr_id;
    logic [DATA_W-1:0] i_wbu_gpr_wr_data;

    // Decode-side read ports and issue marking
    logic [ID_W-1:0]   i_idu_rs1_id;
    logic [ID_W-1:0]   i_idu_rs2_id;
    logic [DATA_W-1:0] o_gpr_rs1_data;
    logic [DATA_W-1:0] o_gpr_rs2_data;
    logic              o_gpr_rs1_busy;
    logic              o_gpr_rs2_busy;
    logic              i_idu_issue_en;
    logic [ID_W-1:0]   i_idu_issue_id;
    logic [ID_W:0]     o_gpr_busy_cnt;

    modport master (
        output i_sys_valid,
        input  o_sys_ready,
        output i_wbu_gpr_wr_en,
        output i_wbu_gpr_wr_id,
        output i_wbu_gpr_wr_data,
        output i_idu_rs1_id,
        output i_idu_rs2_id,
        input  o_gpr_rs1_data,
        input  o_gpr_rs2_data,
        input  o_gpr_rs1_busy,
        input  o_gpr_rs2_busy,
        output i_idu_issue_en,
        output i_idu_issue_id,
        input  o_gpr_busy_cnt
    );

    modport slave (
        input  i_sys_valid,
        output o_sys_ready,
        input  i_wbu_gpr_wr_en,
        input  i_wbu_gpr_wr_id,
        input  i_wbu_gpr_wr_data,
        input  i_idu_rs1_id,
        input  i_idu_rs2_id,
        output o_gpr_rs1_data,
        output o_gpr_rs2_data,
        output o_gpr_rs1_busy,
        output o_gpr_rs2_busy,
        input  i_idu_issue_en,
        input  i_idu_issue_id,
        output o_gpr_busy_cnt
    );
endinterface
`default_nettype wire

// File: rtl/gpr_file.sv
`default_nettype none
// ============================================================================
// Module      : gpr_file
// Description : 2R/1W general-purpose register file with write-through bypass
//               and a per-register pending-write scoreboard.
// Revision    : 1.0
// ============================================================================
module gpr_file #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 5
) (
    input  wire logic   i_clk,
    input  wire logic   i_rst_n,
    gpr_file_if.slave   bus
);

    localparam int             c_NUM_REGS = 1 << ID_W;
    localparam int             c_NUM_RD   = 2;
    localparam [ID_W-1:0]      c_ID_ZERO  = '0;
    localparam [c_NUM_REGS-1:0] c_ONE_HOT = {{(c_NUM_REGS-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0]     r_gpr [c_NUM_REGS];
    logic [c_NUM_REGS-1:0] r_busy;
    logic [ID_W:0]         r_busy_cnt;
    logic                  r_sys_ready;

    logic                  w_wr_fire;
    logic                  w_set_hit;
    logic                  w_cnt_inc;
    logic                  w_cnt_dec;
    logic [c_NUM_REGS-1:0] w_set_mask;
    logic [c_NUM_REGS-1:0] w_clr_mask;
    logic [c_NUM_REGS-1:0] w_busy_nxt;
    logic [ID_W:0]         w_busy_cnt_nxt;

    logic [ID_W-1:0]       w_rd_id   [c_NUM_RD];
    logic [DATA_W-1:0]     w_rd_data [c_NUM_RD];
    logic                  w_rd_busy [c_NUM_RD];

    // Writes to x0 never fire, so they neither store nor clear the scoreboard.
    assign w_wr_fire = bus.i_sys_valid && r_sys_ready && bus.i_wbu_gpr_wr_en
                       && (bus.i_wbu_gpr_wr_id != c_ID_ZERO);

    assign w_set_hit  = bus.i_idu_issue_en && (bus.i_idu_issue_id != c_ID_ZERO);
    assign w_set_mask = w_set_hit ? (c_ONE_HOT << bus.i_idu_issue_id) : '0;
    assign w_clr_mask = w_wr_fire ? (c_ONE_HOT << bus.i_wbu_gpr_wr_id) : '0;

    // Set after clear: a same-cycle re-issue keeps the register busy.
    assign w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;

    assign w_cnt_inc = w_set_hit && !r_busy[bus.i_idu_issue_id];
    assign w_cnt_dec = w_wr_fire && r_busy[bus.i_wbu_gpr_wr_id]
                       && !(w_set_hit && (bus.i_idu_issue_id == bus.i_wbu_gpr_wr_id));

    assign w_busy_cnt_nxt = r_busy_cnt + (ID_W+1)'(w_cnt_inc) - (ID_W+1)'(w_cnt_dec);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_gpr[i] <= '0;
            end
        end else if (w_wr_fire) begin
            r_gpr[bus.i_wbu_gpr_wr_id] <= bus.i_wbu_gpr_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy      <= '0;
            r_busy_cnt  <= '0;
            r_sys_ready <= 1'b0;
        end else begin
            r_busy      <= w_busy_nxt;
            r_busy_cnt  <= w_busy_cnt_nxt;
            r_sys_ready <= 1'b1;
        end
    end

    assign w_rd_id[0] = bus.i_idu_rs1_id;
    assign w_rd_id[1] = bus.i_idu_rs2_id;

    for (genvar p = 0; p < c_NUM_RD; p++) begin : g_rd_port
        logic w_bypass;

        assign w_bypass     = w_wr_fire && (bus.i_wbu_gpr_wr_id == w_rd_id[p]);
        assign w_rd_data[p] = (w_rd_id[p] == c_ID_ZERO) ? '0 :
                              w_bypass                  ? bus.i_wbu_gpr_wr_data :
                                                          r_gpr[w_rd_id[p]];
        // r_busy[0] is never set, so x0 reads as not busy without a special case.
        assign w_rd_busy[p] = r_busy[w_rd_id[p]] && !w_bypass;
    end

    assign bus.o_gpr_rs1_data = w_rd_data[0];
    assign bus.o_gpr_rs2_data = w_rd_data[1];
    assign bus.o_gpr_rs1_busy = w_rd_busy[0];
    assign bus.o_gpr_rs2_busy = w_rd_busy[1];
    assign bus.o_gpr_busy_cnt = r_busy_cnt;
    assign bus.o_sys_ready    = r_sys_ready;

endmodule
`default_nettype wire

// File: tb/tb_gpr_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpr_file
// Description : Directed scoreboard bench for gpr_file.
// Revision    : 1.0
// ============================================================================
module tb_gpr_file;

    logic clk;
    logic rst_n;

    int n_tests;
    int n_fail;
    logic [31:0] exp_q [$];

    gpr_file_if #(.DATA_W(32), .ID_W(5)) bus ();

    gpr_file #(.DATA_W(32), .ID_W(5)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %h expected <scoreboard empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_sys_valid       = 1'b0;
        bus.i_wbu_gpr_wr_en   = 1'b0;
        bus.i_wbu_gpr_wr_id   = '0;
        bus.i_wbu_gpr_wr_data = '0;
        bus.i_idu_issue_en    = 1'b0;
        bus.i_idu_issue_id    = '0;
    endtask

    task automatic drive_wr(input logic [4:0] id, input logic [31:0] data);
        bus.i_sys_valid       = 1'b1;
        bus.i_wbu_gpr_wr_en   = 1'b1;
        bus.i_wbu_gpr_wr_id   = id;
        bus.i_wbu_gpr_wr_data = data;
    endtask

    task automatic drive_issue(input logic [4:0] id);
        bus.i_idu_issue_en = 1'b1;
        bus.i_idu_issue_id = id;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        idle();
        bus.i_idu_rs1_id = 5'd5;
        bus.i_idu_rs2_id = 5'd31;

        // Reset release
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        push_exp(32'h0); check("ready_release_cycle", 32'(bus.o_sys_ready));
        push_exp(32'h0); check("rst_rs1_data", bus.o_gpr_rs1_data);
        push_exp(32'h0); check("rst_rs2_data", bus.o_gpr_rs2_data);
        push_exp(32'h0); check("rst_rs1_busy", 32'(bus.o_gpr_rs1_busy));
        push_exp(32'h0); check("rst_busy_cnt", 32'(bus.o_gpr_busy_cnt));
        tick();
        push_exp(32'h1); check("ready_after_edge", 32'(bus.o_sys_ready));

        // Write then read, bypass in the write cycle
        drive_wr(5'd5, 32'hDEADBEEF);
        bus.i_idu_rs1_id = 5'd5;
        bus.i_idu_rs2_id = 5'd6;
        #1;
        push_exp(32'hDEADBEEF); check("bypass_rs1", bus.o_gpr_rs1_data);
        push_exp(32'h0);        check("bypass_other_rs2", bus.o_gpr_rs2_data);
        tick();
        idle();
        bus.i_idu_rs2_id = 5'd5;
        #1;
        push_exp(32'hDEADBEEF); check("stored_rs1", bus.o_gpr_rs1_data);
        push_exp(32'hDEADBEEF); check("stored_rs2", bus.o_gpr_rs2_data);

        // x0 protection
        drive_wr(5'd0, 32'h12345678);
        drive_issue(5'd0);
        bus.i_idu_rs1_id = 5'd0;
        #1;
        push_exp(32'h0); check("x0_bypass", bus.o_gpr_rs1_data);
        tick();
        idle();
        #1;
        push_exp(32'h0); check("x0_data", bus.o_gpr_rs1_data);
        push_exp(32'h0); check("x0_busy", 32'(bus.o_gpr_rs1_busy));
        push_exp(32'h0); check("x0_cnt", 32'(bus.o_gpr_busy_cnt));

        // Scoreboard set by issue, cleared by write
        drive_issue(5'd7);
        bus.i_idu_rs2_id = 5'd7;
        #1;
        push_exp(32'h0); check("issue_x7_same_cycle", 32'(bus.o_gpr_rs2_busy));
        tick();
        idle();
        #1;
        push_exp(32'h1); check("x7_busy", 32'(bus.o_gpr_rs2_busy));
        push_exp(32'h1); check("x7_cnt", 32'(bus.o_gpr_busy_cnt));
        drive_wr(5'd7, 32'h000000A5);
        bus.i_idu_rs1_id = 5'd7;
        #1;
        push_exp(32'h0);  check("x7_clear_comb", 32'(bus.o_gpr_rs2_busy));
        push_exp(32'hA5); check("x7_wr_data", bus.o_gpr_rs1_data);
        push_exp(32'h1);  check("x7_cnt_hold", 32'(bus.o_gpr_busy_cnt));
        tick();
        idle();
        #1;
        push_exp(32'h0); check("x7_cnt_cleared", 32'(bus.o_gpr_busy_cnt));
        push_exp(32'h0); check("x7_busy_cleared", 32'(bus.o_gpr_rs2_busy));

        // Simultaneous set and clear of the same register
        drive_issue(5'd9);
        bus.i_idu_rs1_id = 5'd9;
        bus.i_idu_rs2_id = 5'd3;
        tick();
        idle();
        #1;
        push_exp(32'h1); check("x9_busy", 32'(bus.o_gpr_rs1_busy));
        drive_wr(5'd9, 32'h1);
        drive_issue(5'd9);
        #1;
        push_exp(32'h0); check("x9_setclr_comb", 32'(bus.o_gpr_rs1_busy));
        tick();
        idle();
        #1;
        push_exp(32'h1); check("x9_set_wins", 32'(bus.o_gpr_rs1_busy));
        push_exp(32'h1); check("x9_set_wins_cnt", 32'(bus.o_gpr_busy_cnt));
        push_exp(32'h1); check("x9_data", bus.o_gpr_rs1_data);

        // Clear x9 while setting x3
        drive_wr(5'd9, 32'h2);
        drive_issue(5'd3);
        tick();
        idle();
        #1;
        push_exp(32'h1); check("swap_cnt", 32'(bus.o_gpr_busy_cnt));
        push_exp(32'h0); check("swap_x9_free", 32'(bus.o_gpr_rs1_busy));
        push_exp(32'h1); check("swap_x3_busy", 32'(bus.o_gpr_rs2_busy));
        drive_wr(5'd3, 32'h33);
        tick();
        idle();
        #1;
        push_exp(32'h0); check("x3_cleared_cnt", 32'(bus.o_gpr_busy_cnt));

        // Saturation: issue x1..x31 back to back
        for (int k = 1; k < 32; k++) begin
            drive_issue(5'(k));
            #1;
            push_exp(32'(k - 1)); check("sat_cnt_ramp", 32'(bus.o_gpr_busy_cnt));
            tick();
        end
        idle();
        bus.i_idu_rs1_id = 5'd31;
        bus.i_idu_rs2_id = 5'd1;
        #1;
        push_exp(32'd31); check("sat_cnt_full", 32'(bus.o_gpr_busy_cnt));
        push_exp(32'h1);  check("sat_x31_busy", 32'(bus.o_gpr_rs1_busy));
        push_exp(32'h1);  check("sat_x1_busy", 32'(bus.o_gpr_rs2_busy));
        drive_issue(5'd5);
        tick();
        idle();
        #1;
        push_exp(32'd31); check("sat_reissue_no_wrap", 32'(bus.o_gpr_busy_cnt));

        // Mid-operation asynchronous reset
        for (int k = 1; k < 7; k++) begin
            drive_issue(5'(k));
            tick();
        end
        bus.i_idu_rs1_id = 5'd5;
        bus.i_idu_rs2_id = 5'd12;
        #2;
        rst_n = 1'b0;
        idle();
        drive_wr(5'd12, 32'hCAFEF00D);
        #1;
        push_exp(32'h0); check("midrst_cnt", 32'(bus.o_gpr_busy_cnt));
        push_exp(32'h0); check("midrst_rs1_busy", 32'(bus.o_gpr_rs1_busy));
        push_exp(32'h0); check("midrst_rs1_data", bus.o_gpr_rs1_data);
        push_exp(32'h0); check("midrst_ready", 32'(bus.o_sys_ready));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        push_exp(32'h0); check("midrst_release_rs2", bus.o_gpr_rs2_data);
        tick();
        idle();
        #1;
        push_exp(32'h1); check("midrst_ready_up", 32'(bus.o_sys_ready));
        push_exp(32'h0); check("midrst_wr_lost", bus.o_gpr_rs2_data);
        push_exp(32'h0); check("midrst_cnt_after", 32'(bus.o_gpr_busy_cnt));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
